alu_datapath_seq: RTL

Parametrised, multi-cycle successor to the byte ALU datapath. Operand buffers A and B are loaded from a shared data bus. A start strobe launches one operation through a small FSM, and a one-cycle alu_done pulse marks the result. Adds width and latency parameters, signed/unsigned overflow selection, extra opcodes, busy back-pressure, illegal-opcode flagging and an asynchronous reset. Sits between the ALU control/test sequencer and the result consumer.

---
 rtl/alu_datapath_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_datapath_seq.sv
// Multi-cycle ALU datapath: operand buffers loaded from a shared bus, one operation per start strobe.
// busy, alu_done and the result registers follow the FSM state by one cycle, so alu_done lands EXEC_CYCLES+1 edges after launch.
//
// state | meaning
// IDLE  | accepting buffer loads and start (only once busy has dropped)
// EXEC  | counting down EXEC_CYCLES cycles on the latched operands
// DONE  | operation complete; result, flags and alu_done register on leaving
module alu_datapath_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int EXEC_CYCLES = 2,
  parameter int SIGNED_OVF  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic [2:0]            opcode_value,
  input  logic                  store_a,
  input  logic                  store_b,
  input  logic                  start,
  output logic                  busy,
  output logic                  alu_done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow_def,
  output logic                  op_error
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W);
  localparam int CW  = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_buf_a, r_buf_b, r_a, r_b, r_result;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_done, r_ovf, r_err;
  logic            w_accept, w_launch;
  logic [W:0]      w_sum, w_diff;
  logic [SHW-1:0]  w_shamt;
  logic [2*W-1:0]  w_shl_wide;
  logic [W-1:0]    w_res;
  logic            w_ovf, w_err;

  // Hold off new commands until the registered busy has dropped, so a load can never slip in while busy=1.
  assign w_accept = (r_state == S_IDLE) && !r_busy;
  assign w_launch = w_accept && start && !store_a && !store_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = S_EXEC;
      S_EXEC:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_a  <= '0;
      r_buf_b  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_DONE);
      if (w_accept) begin
        if (store_a)      r_buf_a <= alu_data;
        else if (store_b) r_buf_b <= alu_data;
      end
      if (w_launch) begin
        r_op  <= opcode_value;
        r_a   <= r_buf_a;
        r_b   <= r_buf_b;
        r_cnt <= CNT_LOAD;
      end else if (r_state == S_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == S_DONE) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_err    <= w_err;
      end
    end
  end

  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
  assign w_shamt    = r_b[SHW-1:0];
  assign w_shl_wide = {{W{1'b0}}, r_a} << w_shamt;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (r_op)
      3'd0: begin
        w_res = w_sum[W-1:0];
        w_ovf = (SIGNED_OVF != 0)
              ? ((r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]))
              : w_sum[W];
      end
      3'd1: begin
        w_res = w_diff[W-1:0];
        w_ovf = (SIGNED_OVF != 0)
              ? ((r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]))
              : w_diff[W];
      end
      3'd2: w_res = {{(W-1){1'b0}}, ^(r_a ^ r_b)};
      3'd3: w_res = ~(r_a ^ r_b);
      3'd4: w_res = r_a & r_b;
      3'd5: w_res = r_a | r_b;
      3'd6: begin
        // Only reachable for non-power-of-two widths, where the masked amount can still exceed W-1.
        if (int'(w_shamt) >= W) begin
          w_res = '0;
          w_ovf = |r_a;
        end else begin
          w_res = w_shl_wide[W-1:0];
          w_ovf = |w_shl_wide[2*W-1:W];
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  assign busy         = r_busy;
  assign alu_done     = r_done;
  assign result       = r_result;
  assign overflow_def = r_ovf;
  assign op_error     = r_err;

endmodule
